// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: default rates, divisor helpers and the
// frame state type used by both the transmit and receive state machines.
package uart_pkg;

    localparam int DEF_CLK_HZ     = 50_000_000;
    localparam int DEF_BAUD       = 115_200;
    localparam int DEF_OVERSAMPLE = 16;

    // Clock cycles per transmitted bit (integer division, truncating).
    function automatic int tx_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Clock cycles per receive oversample tick (integer division, truncating).
    function automatic int rx_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

    localparam int TX_DIV = tx_div(DEF_CLK_HZ, DEF_BAUD);                  // 434
    localparam int RX_DIV = rx_div(DEF_CLK_HZ, DEF_BAUD, DEF_OVERSAMPLE);  // 27

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Programmable divider producing a single-cycle tick once every DIV enabled
// cycles. A synchronous reset restarts the period from zero.
module uart_baud_tick #(
    parameter int DIV = 434
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Next count: wrap on the last cycle of the period, hold while disabled.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Period counter register.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART. The transmitter serialises one byte per accepted
// write strobe; the receiver oversamples the synchronised line, assembles a
// byte and presents it with a sticky ready flag until the consumer clears it.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic       clk_50m,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic       rdy,
    input  logic       rdy_clr,
    output logic [7:0] dout
);

    localparam int TX_CYCLES = tx_div(CLK_HZ, BAUD);
    localparam int RX_CYCLES = rx_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int SW        = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    uart_state_e tx_state_q, tx_state_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_bit_q,   tx_bit_d;
    logic        tx_q,       tx_d;
    logic        tx_accept;
    logic        tx_tick;

    // A strobe is only taken while idle; the bit timer restarts with it.
    assign tx_accept = wr_en && (tx_state_q == ST_IDLE);

    uart_baud_tick #(.DIV(TX_CYCLES)) u_tx_tick (
        .clk_i   (clk_50m),
        .reset_i (reset || tx_accept),
        .en_i    (tx_state_q != ST_IDLE),
        .tick_o  (tx_tick)
    );

    // TX next state: start bit, eight data bits LSB first, stop bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        unique case (tx_state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    tx_state_d = ST_START;
                    tx_shift_d = din;
                    tx_bit_d   = '0;
                    tx_d       = 1'b0;
                end
            end
            ST_START: begin
                if (tx_tick) begin
                    tx_state_d = ST_DATA;
                    tx_d       = tx_shift_q[0];
                end
            end
            ST_DATA: begin
                if (tx_tick) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tx_tick) begin
                    tx_state_d = ST_IDLE;
                    tx_d       = 1'b1;
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    // TX state register; the serial pin is registered to stay glitch-free.
    always_ff @(posedge clk_50m) begin
        if (reset) begin
            tx_state_q <= ST_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (tx_state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic [1:0]    rx_sync_q;
    logic          rx_s;
    logic          rx_tick;
    uart_state_e   rx_state_q, rx_state_d;
    logic [SW-1:0] rx_cnt_q,   rx_cnt_d;
    logic [2:0]    rx_bit_q,   rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rdy_q,      rdy_d;
    logic [7:0]    dout_q,     dout_d;

    // Two-flop synchroniser for the asynchronous line, resetting to idle-high.
    always_ff @(posedge clk_50m) begin
        if (reset) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx};
        end
    end

    assign rx_s = rx_sync_q[1];

    uart_baud_tick #(.DIV(RX_CYCLES)) u_rx_tick (
        .clk_i   (clk_50m),
        .reset_i (reset),
        .en_i    (1'b1),
        .tick_o  (rx_tick)
    );

    // RX next state: qualify the start bit at mid-bit, then sample each
    // following bit a full bit period later; a completed byte beats rdy_clr.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rdy_d      = rdy_q;
        dout_d     = dout_q;
        if (rdy_clr) begin
            rdy_d = 1'b0;
        end
        if (rx_tick) begin
            unique case (rx_state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        rx_state_d = ST_START;
                        rx_cnt_d   = '0;
                    end
                end
                ST_START: begin
                    if (rx_cnt_q == SMP_MID) begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt_q + SW'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_q == SMP_LAST) begin
                        rx_cnt_d   = '0;
                        rx_shift_d = {rx_s, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = ST_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + SW'(1);
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_q == SMP_LAST) begin
                        rx_cnt_d   = '0;
                        rx_state_d = ST_IDLE;
                        if (rx_s) begin
                            dout_d = rx_shift_q;
                            rdy_d  = 1'b1;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + SW'(1);
                    end
                end
                default: begin
                    rx_state_d = ST_IDLE;
                    rx_cnt_d   = '0;
                end
            endcase
        end
    end

    // RX state, sample counters and the held output byte.
    always_ff @(posedge clk_50m) begin
        if (reset) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rdy_q      <= 1'b0;
            dout_q     <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rdy_q      <= rdy_d;
            dout_q     <= dout_d;
        end
    end

    assign rdy  = rdy_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: a frame-level model of the line
// and the receive flags is compared against the DUT on every cycle, and
// directed tests pin key points with hand-computed values.
module tb_uart_transceiver;

    localparam int BIT = 434;

    logic       clk_50m = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] din     = 8'h00;
    logic       wr_en   = 1'b0;
    logic       rdy_clr = 1'b0;
    logic       rx_drv  = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_line;
    logic       tx;
    logic       tx_busy;
    logic       rdy;
    logic [7:0] dout;

    assign rx_line = loop_en ? tx : rx_drv;

    uart_transceiver dut (
        .clk_50m (clk_50m),
        .reset   (reset),
        .din     (din),
        .wr_en   (wr_en),
        .tx      (tx),
        .tx_busy (tx_busy),
        .rx      (rx_line),
        .rdy     (rdy),
        .rdy_clr (rdy_clr),
        .dout    (dout)
    );

    always #10 clk_50m = ~clk_50m;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk_50m) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a transmitted frame is 10 bits of BIT cycles each; the line
    // value is just the frame bit indexed by elapsed cycles. Receive flags
    // are set by the stimulus when a good frame ends and cleared by rdy_clr.
    // ------------------------------------------------------------------
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [9:0] m_frame  = 10'h3FF;
    logic       exp_rdy  = 1'b0;
    logic [7:0] exp_dout = 8'h00;
    bit         rx_hold  = 1'b0;
    bit         cmp_en   = 1'b0;

    always @(posedge clk_50m) begin
        if (reset) begin
            m_active = 1'b0;
            m_pos    = 0;
            exp_rdy  = 1'b0;
            exp_dout = 8'h00;
        end else begin
            if (m_active) begin
                if (m_pos == 10 * BIT - 1) m_active = 1'b0;
                else                       m_pos++;
            end else if (wr_en) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_frame  = {1'b1, din, 1'b0};
            end
            if (rdy_clr && !rx_hold) exp_rdy = 1'b0;
        end
    end

    always @(negedge clk_50m) begin : compare
        logic exp_tx;
        if (cmp_en) begin
            exp_tx = m_active ? m_frame[m_pos / BIT] : 1'b1;
            check("tx_line", tx, exp_tx);
            check("tx_busy", tx_busy, m_active);
            if (!rx_hold) begin
                check("rdy", rdy, exp_rdy);
                check("dout", dout, exp_dout);
            end
        end
    end

    // Send one byte, check the mid-bit line against hand-computed bits,
    // optionally pulse wr_en with din=FF at cycle inject_at of the frame,
    // and check the busy window length.
    task automatic send_tx(input logic [7:0] b, input logic [9:0] lit,
                           input int inject_at, input string tag);
        int p;
        din   = b;
        wr_en = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
        din   = 8'h00;
        check({tag, "_first_tx"}, tx, 1'b0);
        check({tag, "_first_busy"}, tx_busy, 1'b1);
        p = 0;
        while (tx_busy === 1'b1 && p < 5000) begin
            if ((p % BIT) == BIT / 2) check({tag, "_midbit"}, tx, lit[p / BIT]);
            @(negedge clk_50m);
            p++;
            wr_en = (p == inject_at);
            din   = (p == inject_at) ? 8'hFF : 8'h00;
        end
        wr_en = 1'b0;
        check({tag, "_busy_cycles"}, p, 4340);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (tx_busy !== 1'b0 && k < 6000) begin
            @(negedge clk_50m);
            k++;
        end
        check({tag, "_idle_wait"}, tx_busy, 1'b0);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit, input bit probe);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            if (probe && i == 9) check("rx_rdy_before_stop", rdy, 1'b0);
            repeat (BIT) @(negedge clk_50m);
        end
        rx_drv = 1'b1;
    endtask

    initial begin : stim
        int k;
        // Reset held for three cycles.
        reset = 1'b1;
        repeat (3) @(posedge clk_50m);
        @(negedge clk_50m);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_rdy", rdy, 1'b0);
        check("reset_dout", dout, 8'h00);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Transmit A5: line 0,1,0,1,0,0,1,0,1 then stop 1.
        send_tx(8'hA5, 10'b11_0100_1010, -1, "tx_a5");
        repeat (20) @(negedge clk_50m);

        // Transmit 12 with a rejected FF strobe at cycle 1000.
        send_tx(8'h12, 10'b10_0010_0100, 1000, "tx_12");
        repeat (1000) @(negedge clk_50m);
        check("tx_12_no_second_frame", tx_busy, 1'b0);

        // Reset mid-frame aborts the frame and returns the line high.
        din   = 8'hF0;
        wr_en = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
        repeat (1500) @(negedge clk_50m);
        check("abort_tx_low_before", tx, 1'b0);
        reset = 1'b1;
        @(negedge clk_50m);
        reset = 1'b0;
        check("abort_tx_high", tx, 1'b1);
        check("abort_busy", tx_busy, 1'b0);
        repeat (50) @(negedge clk_50m);

        // Receive 3C; rdy rises during the stop bit and is sticky.
        rx_hold = 1'b1;
        drive_rx(8'h3C, 1'b1, 1'b1);
        check("rx_3c_rdy", rdy, 1'b1);
        check("rx_3c_dout", dout, 8'h3C);
        exp_rdy  = 1'b1;
        exp_dout = 8'h3C;
        rx_hold  = 1'b0;
        repeat (500) @(negedge clk_50m);
        check("rx_3c_rdy_sticky", rdy, 1'b1);
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
        check("rx_3c_rdy_cleared", rdy, 1'b0);

        // Framing error on 55: nothing changes.
        drive_rx(8'h55, 1'b0, 1'b0);
        repeat (1000) @(negedge clk_50m);
        check("frame_err_rdy", rdy, 1'b0);
        check("frame_err_dout", dout, 8'h3C);

        // 100-cycle glitch on the idle line: no reception.
        rx_drv = 1'b0;
        repeat (100) @(negedge clk_50m);
        rx_drv = 1'b1;
        repeat (1000) @(negedge clk_50m);
        check("glitch_rdy", rdy, 1'b0);
        check("glitch_dout", dout, 8'h3C);

        // Loopback: 00 then FF back-to-back.
        loop_en = 1'b1;
        rx_hold = 1'b1;
        din     = 8'h00;
        wr_en   = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
        k = 0;
        while (rdy !== 1'b1 && k < 6000) begin
            @(negedge clk_50m);
            k++;
        end
        check("loop_00_rdy", rdy, 1'b1);
        check("loop_00_dout", dout, 8'h00);
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
        check("loop_00_rdy_cleared", rdy, 1'b0);
        wait_idle("loop_00");
        din   = 8'hFF;
        wr_en = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
        check("loop_ff_back_to_back", tx_busy, 1'b1);
        // Keep rdy_clr high on every cycle rdy is low, so it is high on the
        // very cycle the second byte completes.
        k = 0;
        while (rdy !== 1'b1 && k < 6000) begin
            rdy_clr = 1'b1;
            @(negedge clk_50m);
            k++;
        end
        rdy_clr = 1'b0;
        check("loop_ff_rdy_collision", rdy, 1'b1);
        check("loop_ff_dout", dout, 8'hFF);
        @(negedge clk_50m);
        check("loop_ff_rdy_held", rdy, 1'b1);
        exp_rdy  = 1'b1;
        exp_dout = 8'hFF;
        wait_idle("loop_ff");
        rx_hold = 1'b0;
        loop_en = 1'b0;
        repeat (50) @(negedge clk_50m);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
